reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//   Shares the physical register file's NUM_WRITE_PORTS write ports among NUM_REQ writeback sources (ALU, LSU, FPU, ...).
//   Buffers each source in a small FIFO and grants up to NUM_WRITE_PORTS heads per cycle, round-robin.
//   Drives registered RegFileWritePort structs straight into the register file. Sits between the FU writeback stage and the PRF.
// PARAMETERS
//   WORD_SIZE        reg_pkg::WORD_SIZE      data width
//   NUM_PHYS_REGS    reg_pkg::NUM_PHYS_REGS  PRF depth; index width IDX_W = $clog2(NUM_PHYS_REGS)
//   NUM_REQ          4                       writeback requesters
//   NUM_WRITE_PORTS  2                       PRF write ports driven (1..NUM_REQ)
//   FIFO_DEPTH       2                       entries per requester FIFO (power of 2, >=2)
// PORTS
//   clk          in   1                  clock, all state on posedge
//   rst          in   1                  asynchronous, active-low reset
//   flush        in   1                  sync; drop all buffered and pending writes
//   req_valid    in   [NUM_REQ]          requester i offers a write
//   req_index    in   IDX_W x NUM_REQ    destination phys reg per requester
//   req_data     in   WORD_SIZE x NUM_REQ  write data per requester
//   req_ready    out  [NUM_REQ]          FIFO i can accept; transfer on valid&&ready at posedge
//   write_ports  out  RegFileWritePort x NUM_WRITE_PORTS  {en,index_in,data_in} to PRF
//   busy         out  1                  any FIFO non-empty or any write_ports[k].en high
// BEHAVIOUR
//   Reset (rst=0, async): FIFOs empty, rr_ptr=0, all write_ports fields 0, busy=0; req_ready forced 0 while rst=0.
//   req_ready[i] = !full[i] && !flush. Combinational from count only; a same-cycle pop does not free a slot.
//   Push: valid&&ready at edge t -> entry at FIFO head from cycle t+1 (if FIFO was empty).
//   Grant (comb, each cycle): scan requesters rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - Grant each non-empty head until NUM_WRITE_PORTS grants are made.
//     - Conflict: a head whose index equals an already-granted index this cycle is skipped and retried later.
//     - Granted heads pop at the edge.
//   Port mapping: k-th grant in scan order -> write_ports[k]. Ports are registered: granted in cycle c, en=1 in cycle c+1.
//     Ungranted ports have en=0; index/data hold their previous values.
//   Latency: accept at edge t -> write_ports.en in cycle t+2 (minimum); the PRF commits at the end of that cycle.
//   rr_ptr: after >=1 grant -> (last granted requester + 1) mod NUM_REQ; no grant -> unchanged. Guarantees starvation-freedom.
//   Per-requester order: FIFO order preserved. No ordering guarantee across requesters (rename makes dests unique).
//   Wrap-around: FIFO rd/wr pointers are IDX modulo FIFO_DEPTH with an extra wrap bit; full = ptrs equal except wrap bit.
//   Flush: at the edge with flush=1, all FIFOs empty, all write_ports.en <= 0, rr_ptr held.
//     Pushes and grants in that cycle are discarded. flush has priority over push/pop.
//   Reset mid-operation: all queued writes lost; no partial write_ports output.
//   busy is combinational from FIFO counts and registered en bits.
// STRUCTURE
//   reg_pkg additions: typedef struct packed {logic [IDX_W-1:0] index; logic [WORD_SIZE-1:0] data;} WbReq;
//     localparam WB_FIFO_DEPTH=2. RegFileWritePort is reused unchanged.
//   Sub-module wb_fifo: parameterised WbReq FIFO. push/pop/flush in; full/empty/head out; async active-low rst.
//     Instantiated NUM_REQ times.
//   Top level: generate-loop of wb_fifo, comb round-robin multi-grant with index-conflict mask, write_ports output regs, rr_ptr reg.
// TESTING
//   1 Reset: rst=0 mid-traffic -> write_ports[*].en=0, busy=0, req_ready=0.
//     Release -> req_ready=4'b1111 the next cycle.
//   2 Single write: req0 {idx 5, 0xDEAD} accepted edge t -> write_ports[0]={1,5,0xDEAD} in cycle t+2 only; port1 en=0 throughout.
//   3 All four requesters valid every cycle, distinct idx, rr_ptr=0.
//     Grants {0,1},{2,3},{0,1}... -> exactly 2 writes/cycle.
//     Each requester receives 1 grant per 2 cycles.
//     With FIFO_DEPTH=2, req_ready toggles per requester accordingly.
//   4 Conflict: req1 and req2 heads both target idx 9, rr_ptr=1 -> cycle 1 grants req1 (+req3 if non-empty); req2 waits.
//     The next cycle grants req2 idx 9 -> PRF sees req1 value then req2 value.
//   5 Full FIFO: hold port grants away from req3 (others saturating) until 2 entries queued.
//     -> req_ready[3]=0; a third valid is not accepted.
//     Entries later emerge in push order.
//   6 Flush with all FIFOs holding entries and en=1 pending -> next cycle all en=0, busy=0, req_ready back to 1.
//     No flushed entry ever appears on write_ports.

Source files
------------

// File: rtl/reg_pkg.sv
// reg_pkg: register-file widths and the writeback/write-port structs shared by the PRF write path.
package reg_pkg;
  localparam int WORD_SIZE = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int IDX_W = $clog2(NUM_PHYS_REGS);
  localparam int WB_FIFO_DEPTH = 2;
  typedef struct packed {
    logic en;
    logic [IDX_W-1:0] index_in;
    logic [WORD_SIZE-1:0] data_in;
  } RegFileWritePort;
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [WORD_SIZE-1:0] data;
  } WbReq;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small writeback-request FIFO using wrap-bit pointers; flush empties it and wins over push/pop.
module wb_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  WbReq din,
  output logic full,
  output logic empty,
  output WbReq head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  WbReq mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: buffers NUM_REQ writeback sources and grants up to NUM_WRITE_PORTS
// FIFO heads per cycle round-robin onto registered PRF write ports.
module reg_write_arbiter
  import reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0] req_index,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0] req_ready,
  output RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports,
  output logic busy
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] full, empty, gnt;
  WbReq head [NUM_REQ];
  logic [RW-1:0] rr_ptr, nxt_rr;
  RegFileWritePort [NUM_WRITE_PORTS-1:0] nxt_wp;
  logic hit;
  int cnt;
  assign req_ready = ~full & {NUM_REQ{!flush && rst}};
  genvar i;
  for (i = 0; i < NUM_REQ; i++) begin : g_fifo
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .push(req_valid[i] && req_ready[i]),
      .pop(gnt[i]),
      .din({req_index[i], req_data[i]}),
      .full(full[i]),
      .empty(empty[i]),
      .head(head[i])
    );
  end
  // Scan order rr_ptr, rr_ptr+1, ...; a head matching an index already granted this cycle waits.
  always_comb begin
    gnt = '0;
    nxt_rr = rr_ptr;
    nxt_wp = write_ports;
    cnt = 0;
    hit = 1'b0;
    for (int k = 0; k < NUM_WRITE_PORTS; k++) nxt_wp[k].en = 1'b0;
    for (int j = 0; j < NUM_REQ; j++)
      for (int r = 0; r < NUM_REQ; r++)
        if (r == (int'(rr_ptr) + j) % NUM_REQ && !empty[r] && cnt < NUM_WRITE_PORTS) begin
          hit = 1'b0;
          for (int k = 0; k < NUM_WRITE_PORTS; k++)
            hit = hit | (nxt_wp[k].en && nxt_wp[k].index_in == head[r].index);
          if (!hit) begin
            for (int k = 0; k < NUM_WRITE_PORTS; k++)
              if (k == cnt) nxt_wp[k] = '{1'b1, head[r].index, head[r].data};
            gnt[r] = 1'b1;
            nxt_rr = RW'((r + 1) % NUM_REQ);
            cnt = cnt + 1;
          end
        end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      write_ports <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_WRITE_PORTS; k++) write_ports[k].en <= 1'b0;
    end else begin
      write_ports <= nxt_wp;
      rr_ptr <= nxt_rr;
    end
  always_comb begin
    busy = ~&empty;
    for (int k = 0; k < NUM_WRITE_PORTS; k++) busy = busy | write_ports[k].en;
  end
endmodule
